// File: rtl/shift_add_control_if.sv
// Handshake bundle between the shift-add control FSM and its Counter/datapath neighbours.
interface shift_add_control_if;
  logic Start;
  logic K;
  logic M0;
  logic Load;
  logic Add;
  logic Shift;
  logic Busy;
  logic Done;
  logic Error;

  modport master (
    output Start, K, M0,
    input  Load, Add, Shift, Busy, Done, Error
  );

  modport slave (
    input  Start, K, M0,
    output Load, Add, Shift, Busy, Done, Error
  );
endinterface

// File: rtl/shift_add_control.sv
// Control FSM for the shift-add multiplier: one Load cycle, one add/shift cycle per
// multiplier bit until Counter raises K, with a watchdog that traps a stuck counter.
//
//   state | meaning
//   IDLE  | waiting for Start, all outputs low
//   LOAD  | load operands, reset Counter, clear accumulator
//   RUN   | one shift (plus add when M0) per cycle until K
//   DONE  | one-cycle completion pulse
//   ERROR | watchdog tripped, held until Start clears it
module shift_add_control #(
  parameter int N       = 8,
  parameter int MAX_RUN = N + 4
) (
  input  logic                Clk,
  input  logic                Rst_n,
  shift_add_control_if.slave  bus
);

  // Size the watchdog for whichever is larger so a short MAX_RUN cannot truncate it.
  localparam int WD_LIM = (MAX_RUN > N) ? MAX_RUN : N;
  localparam int CW     = $clog2(WD_LIM + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(MAX_RUN - 1);
  localparam logic [CW-1:0] WD_SAT  = {CW{1'b1}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wd_cnt, wd_cnt_nxt;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state  <= IDLE;
      wd_cnt <= '0;
    end else begin
      state  <= state_nxt;
      wd_cnt <= wd_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    wd_cnt_nxt = wd_cnt;
    bus.Load   = 1'b0;
    bus.Add    = 1'b0;
    bus.Shift  = 1'b0;
    bus.Busy   = 1'b0;
    bus.Done   = 1'b0;
    bus.Error  = 1'b0;

    case (state)
      IDLE: begin
        if (bus.Start) state_nxt = LOAD;
      end
      LOAD: begin
        bus.Load   = 1'b1;
        bus.Busy   = 1'b1;
        wd_cnt_nxt = '0;
        state_nxt  = RUN;
      end
      RUN: begin
        bus.Shift = 1'b1;
        bus.Busy  = 1'b1;
        bus.Add   = bus.M0;
        // K marks the final iteration, so this cycle still shifts before DONE.
        if (bus.K) begin
          state_nxt = DONE;
        end else if (wd_cnt == WD_LAST) begin
          state_nxt = ERROR;
        end else if (wd_cnt != WD_SAT) begin
          wd_cnt_nxt = wd_cnt + 1'b1;
        end
      end
      DONE: begin
        bus.Done  = 1'b1;
        state_nxt = IDLE;
      end
      ERROR: begin
        bus.Error = 1'b1;
        if (bus.Start) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_add_control.sv
// Directed bench for shift_add_control with a behavioural Counter and shift-add datapath.
module tb_shift_add_control;

  localparam int N = 8;

  logic Clk = 1'b0;
  logic Rst_n;
  logic k_force_en;
  logic k_force;
  logic [7:0] mcand, mult;
  logic [7:0] dp_a, dp_q, dp_m;
  logic [3:0] cnt;
  int n_checks = 0;
  int n_fail   = 0;

  shift_add_control_if bus ();

  shift_add_control #(.N(N), .MAX_RUN(N + 4)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // Counter model: cleared by Load, counts every clock, K in its final iteration.
  always @(posedge Clk) begin
    if (!Rst_n || bus.Load) cnt <= 4'd0;
    else                    cnt <= cnt + 4'd1;
  end
  assign bus.K = k_force_en ? k_force : (cnt == 4'd7);

  // Datapath model: {A,Q} accumulates the product, Q[0] feeds M0.
  wire [8:0] dp_sum = {1'b0, dp_a} + (bus.Add ? {1'b0, dp_m} : 9'd0);
  always @(posedge Clk) begin
    if (!Rst_n) begin
      dp_a <= 8'd0;
      dp_q <= 8'd0;
      dp_m <= 8'd0;
    end else if (bus.Load) begin
      dp_a <= 8'd0;
      dp_q <= mult;
      dp_m <= mcand;
    end else if (bus.Shift) begin
      dp_a <= dp_sum[8:1];
      dp_q <= {dp_sum[0], dp_q[7:1]};
    end
  end
  assign bus.M0 = dp_q[0];

  wire [5:0]  outs    = {bus.Load, bus.Add, bus.Shift, bus.Busy, bus.Done, bus.Error};
  wire [15:0] product = {dp_a, dp_q};

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst_n     = 1'b0;
    bus.Start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (outs !== 6'b000000) begin
        n_fail++;
        $display("FAIL reset_outs cycle %0d: got %b expected 000000", i, outs);
      end
    end
    bus.Start = 1'b0;
    Rst_n     = 1'b1;
    step();
    n_checks++;
    if (outs !== 6'b000000) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b expected 000000", outs);
    end
  endtask

  task automatic test_nominal();
    int shifts = 0, done_at = 0, done_w = 0, bad_add = 0, extra_load = 0;
    logic [7:0] addbits = 8'h00;
    mcand     = 8'hA5;
    mult      = 8'h3C;
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    n_checks++;
    if (outs !== 6'b100100) begin
      n_fail++;
      $display("FAIL load_cycle: got %b expected 100100", outs);
    end
    for (int i = 1; i <= 15; i++) begin
      step();
      if (bus.Shift) begin
        if (shifts < 8) addbits[shifts] = bus.Add;
        shifts++;
      end
      if (bus.Add !== (bus.Shift & bus.M0)) bad_add++;
      if (bus.Done) begin
        if (done_at == 0) done_at = i;
        done_w++;
      end
      if (bus.Load) extra_load++;
    end
    n_checks++;
    if (shifts != 8) begin
      n_fail++;
      $display("FAIL nominal_shifts: got %0d expected 8", shifts);
    end
    n_checks++;
    if (addbits !== 8'h3C) begin
      n_fail++;
      $display("FAIL nominal_add_pattern: got %h expected 3c", addbits);
    end
    n_checks++;
    if (bad_add != 0) begin
      n_fail++;
      $display("FAIL nominal_add_mealy: %0d cycles with Add != Shift&M0, expected 0", bad_add);
    end
    // Done is high after the 9th edge, captured downstream on the 10th.
    n_checks++;
    if (done_at != 9) begin
      n_fail++;
      $display("FAIL nominal_done_edge: got %0d expected 9", done_at);
    end
    n_checks++;
    if (done_w != 1) begin
      n_fail++;
      $display("FAIL nominal_done_width: got %0d expected 1", done_w);
    end
    n_checks++;
    if (product !== 16'h26AC) begin
      n_fail++;
      $display("FAIL nominal_product: got %h expected 26ac", product);
    end
    n_checks++;
    if (extra_load != 0) begin
      n_fail++;
      $display("FAIL nominal_extra_load: got %0d expected 0", extra_load);
    end
  endtask

  task automatic test_back_to_back();
    int d1 = 0, d2 = 0, load2 = 0;
    mcand     = 8'h0F;
    mult      = 8'h03;
    bus.Start = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (bus.Load && d1 != 0 && load2 == 0) load2 = i;
      if (bus.Done) begin
        if (d1 == 0) d1 = i;
        else if (d2 == 0) begin
          d2        = i;
          bus.Start = 1'b0;
        end
      end
    end
    bus.Start = 1'b0;
    n_checks++;
    if (d1 != 10) begin
      n_fail++;
      $display("FAIL b2b_first_done: got %0d expected 10", d1);
    end
    n_checks++;
    if (d2 - d1 != 11) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d expected 11", d2 - d1);
    end
    n_checks++;
    if (load2 != 12) begin
      n_fail++;
      $display("FAIL b2b_second_load: got %0d expected 12", load2);
    end
    n_checks++;
    if (product !== 16'h002D) begin
      n_fail++;
      $display("FAIL b2b_product: got %h expected 002d", product);
    end
  endtask

  task automatic test_watchdog();
    int shifts = 0, err_at = 0, dones = 0;
    k_force_en = 1'b1;
    k_force    = 1'b0;
    bus.Start  = 1'b1;
    step();
    bus.Start  = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus.Shift) shifts++;
      if (bus.Error && err_at == 0) err_at = i;
      if (bus.Done) dones++;
    end
    n_checks++;
    if (shifts != 12) begin
      n_fail++;
      $display("FAIL wd_shifts: got %0d expected 12", shifts);
    end
    n_checks++;
    if (err_at != 13) begin
      n_fail++;
      $display("FAIL wd_error_edge: got %0d expected 13", err_at);
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL wd_no_done: got %0d expected 0", dones);
    end
    n_checks++;
    if (outs !== 6'b000001) begin
      n_fail++;
      $display("FAIL wd_error_held: got %b expected 000001", outs);
    end
    bus.Start = 1'b1;
    step();
    n_checks++;
    if (outs !== 6'b000000) begin
      n_fail++;
      $display("FAIL wd_clear: got %b expected 000000", outs);
    end
    bus.Start = 1'b0;
    step();
    n_checks++;
    if (outs !== 6'b000000) begin
      n_fail++;
      $display("FAIL wd_idle_after_clear: got %b expected 000000", outs);
    end
    k_force_en = 1'b0;
  endtask

  task automatic test_abort();
    int flags = 0, shifts = 0, dones = 0;
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    repeat (4) step();
    n_checks++;
    if (bus.Shift !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_in_run: got Shift=%b expected 1", bus.Shift);
    end
    Rst_n = 1'b0;
    step();
    n_checks++;
    if (outs[5:2] !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_outputs: got %b expected 0000", outs[5:2]);
    end
    Rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.Done || bus.Error) flags++;
    end
    n_checks++;
    if (flags != 0) begin
      n_fail++;
      $display("FAIL abort_no_done_error: got %0d expected 0", flags);
    end
    mcand     = 8'h09;
    mult      = 8'h07;
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.Shift) shifts++;
      if (bus.Done) dones++;
    end
    n_checks++;
    if (shifts != 8 || dones != 1) begin
      n_fail++;
      $display("FAIL abort_rerun: got shifts=%0d dones=%0d expected 8 and 1", shifts, dones);
    end
    n_checks++;
    if (product !== 16'h003F) begin
      n_fail++;
      $display("FAIL abort_rerun_product: got %h expected 003f", product);
    end
  endtask

  task automatic test_early_k();
    k_force_en = 1'b1;
    k_force    = 1'b1;
    bus.Start  = 1'b1;
    step();
    bus.Start  = 1'b0;
    step();
    n_checks++;
    if (outs[3:2] !== 2'b11) begin
      n_fail++;
      $display("FAIL early_k_run: got Shift,Busy=%b expected 11", outs[3:2]);
    end
    bus.Start = 1'b1;
    step();
    n_checks++;
    if (outs !== 6'b000010) begin
      n_fail++;
      $display("FAIL early_k_done: got %b expected 000010", outs);
    end
    bus.Start = 1'b0;
    step();
    n_checks++;
    if (outs !== 6'b000000) begin
      n_fail++;
      $display("FAIL early_k_idle: got %b expected 000000", outs);
    end
    step();
    n_checks++;
    if (outs !== 6'b000000) begin
      n_fail++;
      $display("FAIL early_k_start_ignored: got %b expected 000000", outs);
    end
    k_force_en = 1'b0;
  endtask

  initial begin
    Rst_n      = 1'b0;
    bus.Start  = 1'b0;
    k_force_en = 1'b0;
    k_force    = 1'b0;
    mcand      = 8'h00;
    mult       = 8'h00;
    test_reset();
    test_nominal();
    test_back_to_back();
    test_watchdog();
    test_abort();
    test_early_k();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
